bram_window_sequencer: RTL and testbench
========================================

BRAM_WINDOW_SEQUENCER -- requirements
Module: bram_window_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: BRAM address width.
REQ-002 SHALL have parameter NUM_WORDS, default 65536: words per frame (1..2^ADDR_W).
REQ-003 SHALL have parameter RD_LAT, default 1: BRAM read latency in cycles (1..3).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a frame load.
REQ-007 SHALL have port in_valid  in  1  incoming 24-bit pixel-triplet word present on the write-data bus this cycle.
REQ-008 SHALL have port wr_en  out  1  write enable to all three input BRAM banks (port A).
REQ-009 SHALL have port wr_addr  out  ADDR_W  port-A address.
REQ-010 SHALL have port rd_en  out  1  read enable to all three banks (port B).
REQ-011 SHALL have port rd_addr  out  ADDR_W  port-B address.
REQ-012 SHALL have port proc_ready  in  1  processing module can accept a window RD_LAT cycles later.
REQ-013 SHALL have port win_valid  out  1  72-bit concatenated bank output is a valid 3x3 window this cycle.
REQ-014 SHALL have port win_last  out  1  qualifies final win_valid of the frame.
REQ-015 SHALL have port load_done  out  1  level; high from end of load until next start (drives existing transfer_done net).
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after last window delivered.
REQ-017 SHALL have port busy  out  1  high in any state except IDLE and DONE.
REQ-018 SHALL have port drop_err  out  1  sticky; in_valid seen outside LOAD.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, READ, DRAIN, DONE.
REQ-020 IDLE->LOAD SHALL occur on start=1; wr_addr and word counter cleared to 0 on entry.
REQ-021 In LOAD, wr_en SHALL equal in_valid combinationally, wr_addr SHALL be current count, and count SHALL increment on each in_valid.
REQ-022 LOAD->READ SHALL occur in the cycle after the in_valid that writes address NUM_WORDS-1; load_done SHALL rise the same cycle.
REQ-023 In READ, rd_en SHALL equal proc_ready; rd_addr SHALL increment only when rd_en=1; a cycle with proc_ready=0 SHALL hold rd_addr.
REQ-024 win_valid SHALL equal rd_en delayed exactly RD_LAT cycles; win_last SHALL equal (rd_en and rd_addr==NUM_WORDS-1) delayed RD_LAT cycles.
REQ-025 READ->DRAIN SHALL occur after the read of NUM_WORDS-1 issues; rd_en SHALL be 0 in DRAIN.
REQ-026 DRAIN->DONE SHALL occur in the cycle win_last is asserted; frame_done SHALL pulse in that same cycle.
REQ-027 DONE SHALL hold load_done=1 and keep rd_addr/wr_addr at their final values; start in DONE SHALL go to LOAD and clear load_done.
REQ-028 start in LOAD, READ or DRAIN SHALL be ignored.
REQ-029 in_valid in any state other than LOAD SHALL not write (wr_en=0) and SHALL set drop_err; drop_err clears only on reset.
REQ-030 Address counters SHALL be ADDR_W+1 bits internally so NUM_WORDS=2^ADDR_W terminates without wrap; outputs SHALL be the low ADDR_W bits.
REQ-031 NUM_WORDS=1 SHALL work: one write, one read, win_valid and win_last coincide.

Reset
REQ-032 On rst=0 at a clock edge, state SHALL become IDLE, all outputs 0, counters 0, latency pipeline flushed, including mid-LOAD or mid-READ.
REQ-033 Outputs SHALL remain at reset values in the first cycle after rst returns to 1.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding and default ADDR_W/NUM_WORDS/RD_LAT constants, reused by image_processing_module and vga_display_module.
REQ-035 Sub-module valid_delay_line (1-bit, RD_LAT stages, synchronous active-low clear) SHALL generate win_valid/win_last.
REQ-036 Block SHALL contain no BRAM instances; top-level wires its outputs to the three banks.

Verification
REQ-037 NUM_WORDS=8, RD_LAT=1: start, 8 back-to-back in_valid -> wr_addr 0..7, load_done high next cycle, state READ.
REQ-038 proc_ready=1 steady -> rd_addr 0..7 on consecutive cycles, win_valid 8 cycles starting 1 cycle after first rd_en, win_last with 8th, frame_done same cycle.
REQ-039 proc_ready toggled 1,0,1,0 -> rd_addr holds on 0-cycles; win_valid pattern equals rd_en delayed RD_LAT (verify with RD_LAT=3).
REQ-040 in_valid pulsed in IDLE and READ -> no wr_en, drop_err set and stays 1 until rst=0.
REQ-041 rst=0 after 4 of 8 load words -> IDLE, all outputs 0; fresh start reloads from wr_addr 0.
REQ-042 NUM_WORDS=1 and NUM_WORDS=2^ADDR_W (ADDR_W=4) -> correct termination, no address wrap, single frame_done.

Source files
------------

// File: rtl/bram_window_sequencer_pkg.sv
// Shared definitions for the BRAM window sequencer and its neighbours: sequencer state
// encoding and the default frame geometry / read latency.
package bram_window_sequencer_pkg;

  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefNumWords = 65536;
  localparam int unsigned DefRdLat    = 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRead  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/bram_window_sequencer_if.sv
// Control, BRAM-address and window-stream signals of the window sequencer.
// master: the sequencer itself; slave: the surrounding datapath / banks.
interface bram_window_sequencer_if
  import bram_window_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
);

  logic              start;
  logic              in_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              proc_ready;
  logic              win_valid;
  logic              win_last;
  logic              load_done;
  logic              frame_done;
  logic              busy;
  logic              drop_err;

  modport master (
    input  start, in_valid, proc_ready,
    output wr_en, wr_addr, rd_en, rd_addr, win_valid, win_last,
    output load_done, frame_done, busy, drop_err
  );

  modport slave (
    output start, in_valid, proc_ready,
    input  wr_en, wr_addr, rd_en, rd_addr, win_valid, win_last,
    input  load_done, frame_done, busy, drop_err
  );

endinterface

// File: rtl/valid_delay_line.sv
// 1-bit shift register of DEPTH stages with synchronous active-low clear; aligns
// read-issue qualifiers with the BRAM read-data latency.
module valid_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] pipe_q;

  // Shift d through DEPTH stages; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_window_sequencer.sv
// Loads one frame of pixel-triplet words into three BRAM banks (port A), then reads
// them back (port B) under processing-module flow control, flagging valid windows
// RD_LAT cycles after each read. No BRAM lives here; the parent wires the banks.
module bram_window_sequencer
  import bram_window_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned NUM_WORDS = DefNumWords,
  parameter int unsigned RD_LAT    = DefRdLat
) (
  input  logic                    clk,
  input  logic                    rst,
  bram_window_sequencer_if.master bus
);

  // One spare bit so a full 2^ADDR_W frame is counted without wrapping.
  localparam int unsigned     CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0] LastAddr = CntW'(NUM_WORDS - 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic            load_done_q, load_done_d;
  logic            drop_err_q, drop_err_d;

  logic wr_fire;
  logic rd_fire;
  logic rd_last;
  logic win_valid;
  logic win_last;

  assign wr_fire = (state_q == StLoad) & bus.in_valid;
  assign rd_fire = (state_q == StRead) & bus.proc_ready;
  assign rd_last = rd_fire & (rd_cnt_q == LastAddr);

  // Next-state: counters stop on the last address so DONE shows the final addresses.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    load_done_d = load_done_q;
    drop_err_d  = drop_err_q | (bus.in_valid & (state_q != StLoad));
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StLoad;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          load_done_d = 1'b0;
        end
      end
      StLoad: begin
        if (wr_fire) begin
          if (wr_cnt_q == LastAddr) begin
            state_d     = StRead;
            load_done_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
          end
        end
      end
      StRead: begin
        if (rd_fire) begin
          if (rd_last) begin
            state_d = StDrain;
          end else begin
            rd_cnt_d = rd_cnt_q + CntW'(1);
          end
        end
      end
      StDrain: begin
        if (win_last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state and counters, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      load_done_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      load_done_q <= load_done_d;
      drop_err_q  <= drop_err_d;
    end
  end

  valid_delay_line #(
    .DEPTH (RD_LAT)
  ) u_valid_dly (
    .clk (clk),
    .rst (rst),
    .d   (rd_fire),
    .q   (win_valid)
  );

  valid_delay_line #(
    .DEPTH (RD_LAT)
  ) u_last_dly (
    .clk (clk),
    .rst (rst),
    .d   (rd_last),
    .q   (win_last)
  );

  assign bus.wr_en      = wr_fire;
  assign bus.wr_addr    = wr_cnt_q[ADDR_W-1:0];
  assign bus.rd_en      = rd_fire;
  assign bus.rd_addr    = rd_cnt_q[ADDR_W-1:0];
  assign bus.win_valid  = win_valid;
  assign bus.win_last   = win_last;
  assign bus.load_done  = load_done_q;
  // The last window always lands while draining, so this pulses once per frame.
  assign bus.frame_done = (state_q == StDrain) & win_last;
  assign bus.busy       = (state_q == StLoad) | (state_q == StRead) | (state_q == StDrain);
  assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_bram_window_sequencer.sv
// Four sequencer instances with different frame sizes / latencies, checked every cycle
// against a transaction-count reference model (writes, reads, delivered windows).
module tb_bram_window_sequencer;

  localparam int AW   = 4;
  localparam int NDUT = 4;
  localparam int NW  [NDUT] = '{8, 8, 1, 16};
  localparam int LAT [NDUT] = '{1, 3, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] start      = '0;
  logic [NDUT-1:0] in_valid   = '0;
  logic [NDUT-1:0] proc_ready = '0;
  logic [NDUT-1:0] wr_en, rd_en, win_valid, win_last, load_done, frame_done, busy, drop_err;
  logic [AW-1:0]   wr_addr [NDUT];
  logic [AW-1:0]   rd_addr [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bram_window_sequencer_if #(.ADDR_W(AW)) bus ();
    assign bus.start      = start[g];
    assign bus.in_valid   = in_valid[g];
    assign bus.proc_ready = proc_ready[g];
    assign wr_en[g]       = bus.wr_en;
    assign wr_addr[g]     = bus.wr_addr;
    assign rd_en[g]       = bus.rd_en;
    assign rd_addr[g]     = bus.rd_addr;
    assign win_valid[g]   = bus.win_valid;
    assign win_last[g]    = bus.win_last;
    assign load_done[g]   = bus.load_done;
    assign frame_done[g]  = bus.frame_done;
    assign busy[g]        = bus.busy;
    assign drop_err[g]    = bus.drop_err;

    bram_window_sequencer #(
      .ADDR_W    (AW),
      .NUM_WORDS (NW[g]),
      .RD_LAT    (LAT[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Reference model: a frame is described only by how many words were written, read
  // and delivered, plus the cycle at which each issued read's window must appear.
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  bit started [NDUT];
  bit derr    [NDUT];
  int wr_n    [NDUT];
  int rd_n    [NDUT];
  int del_n   [NDUT];
  int arr_q   [NDUT][$];

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, k, cyc_no, obs, exp);
    end
  endtask

  task automatic check_dut(int k);
    int n        = NW[k];
    bit loading  = started[k] && wr_n[k] < n;
    bit reading  = started[k] && wr_n[k] == n && rd_n[k] < n;
    bit draining = started[k] && rd_n[k] == n && del_n[k] < n;
    bit win      = arr_q[k].size() != 0 && arr_q[k][0] == cyc_no;
    bit last     = win && del_n[k] == n - 1;
    chk("wr_en", k, 32'(wr_en[k]), 32'(loading && in_valid[k]));
    chk("wr_addr", k, 32'(wr_addr[k]), started[k] ? 32'(min_i(wr_n[k], n - 1)) : 32'd0);
    chk("rd_en", k, 32'(rd_en[k]), 32'(reading && proc_ready[k]));
    chk("rd_addr", k, 32'(rd_addr[k]), started[k] ? 32'(min_i(rd_n[k], n - 1)) : 32'd0);
    chk("win_valid", k, 32'(win_valid[k]), 32'(win));
    chk("win_last", k, 32'(win_last[k]), 32'(last));
    chk("load_done", k, 32'(load_done[k]), 32'(started[k] && wr_n[k] == n));
    chk("frame_done", k, 32'(frame_done[k]), 32'(last));
    chk("busy", k, 32'(busy[k]), 32'(loading || reading || draining));
    chk("drop_err", k, 32'(drop_err[k]), 32'(derr[k]));
  endtask

  task automatic model_update(int k);
    int n        = NW[k];
    bit loading  = started[k] && wr_n[k] < n;
    bit reading  = started[k] && wr_n[k] == n && rd_n[k] < n;
    bit can_go   = !started[k] || del_n[k] == n;
    if (!rst) begin
      started[k] = 1'b0;
      derr[k]    = 1'b0;
      wr_n[k]    = 0;
      rd_n[k]    = 0;
      del_n[k]   = 0;
      arr_q[k].delete();
      return;
    end
    if (arr_q[k].size() != 0 && arr_q[k][0] == cyc_no) begin
      void'(arr_q[k].pop_front());
      del_n[k]++;
    end
    if (in_valid[k] && !loading) derr[k] = 1'b1;
    if (can_go && start[k]) begin
      started[k] = 1'b1;
      wr_n[k]    = 0;
      rd_n[k]    = 0;
      del_n[k]   = 0;
      arr_q[k].delete();
    end else begin
      if (loading && in_valid[k]) wr_n[k]++;
      if (reading && proc_ready[k]) begin
        rd_n[k]++;
        arr_q[k].push_back(cyc_no + LAT[k]);
      end
    end
  endtask

  // One clock: check all outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    #1;
    for (int k = 0; k < NDUT; k++) check_dut(k);
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_update(k);
    cyc_no++;
    @(negedge clk);
  endtask

  // Run an already-started frame to completion; stray starts must be ignored.
  task automatic drive_frame(int k, int pin, int prdy, bit toggle);
    int t = 0;
    while (t < 400 && del_n[k] != NW[k]) begin
      in_valid[k]   = (wr_n[k] < NW[k]) && ($urandom_range(99) < pin);
      proc_ready[k] = toggle ? (t % 2 == 0) : ($urandom_range(99) < prdy);
      start[k]      = ($urandom_range(9) == 0);
      cyc();
      t++;
    end
    in_valid[k]   = 1'b0;
    proc_ready[k] = 1'b0;
    start[k]      = 1'b0;
    chk("frame_timeout", k, 32'(t < 400), 32'd1);
    cyc();
  endtask

  task automatic run_frame(int k, int pin, int prdy, bit toggle);
    start[k] = 1'b1;
    cyc();
    start[k] = 1'b0;
    drive_frame(k, pin, prdy, toggle);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    // Reset state, then the first cycle after release.
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Back-to-back load, steady proc_ready.
    run_frame(0, 100, 100, 1'b0);
    // Alternating proc_ready on the 3-cycle latency instance.
    run_frame(1, 100, 0, 1'b1);
    // Single-word and full 2^ADDR_W frames.
    run_frame(2, 100, 100, 1'b0);
    run_frame(3, 100, 100, 1'b0);

    // Random gaps on writes and reads, restarting from DONE.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NDUT; k++) begin
        run_frame(k, 30 + 30 * r, 40 + 20 * r, 1'b0);
      end
    end

    // Dropped words in IDLE and in READ; sticky until reset.
    do_reset();
    in_valid[0] = 1'b1;
    cyc();
    in_valid[0] = 1'b0;
    repeat (2) cyc();
    start[1] = 1'b1;
    cyc();
    start[1]    = 1'b0;
    in_valid[1] = 1'b1;
    for (int t = 0; t < 40 && wr_n[1] < NW[1]; t++) cyc();
    cyc();
    in_valid[1] = 1'b0;
    drive_frame(1, 0, 100, 1'b0);
    repeat (2) cyc();
    do_reset();

    // Reset part-way through a load, then a clean reload from address 0.
    start[0] = 1'b1;
    cyc();
    start[0]    = 1'b0;
    in_valid[0] = 1'b1;
    repeat (4) cyc();
    in_valid[0] = 1'b0;
    do_reset();
    run_frame(0, 100, 100, 1'b0);

    // Reset part-way through a read with windows still in flight.
    start[3] = 1'b1;
    cyc();
    start[3]    = 1'b0;
    in_valid[3] = 1'b1;
    for (int t = 0; t < 40 && wr_n[3] < NW[3]; t++) cyc();
    in_valid[3]   = 1'b0;
    proc_ready[3] = 1'b1;
    repeat (3) cyc();
    proc_ready[3] = 1'b0;
    do_reset();
    run_frame(3, 70, 70, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
